// File: rtl/sa_autosa_sdp_rdma_split.sv
// sa_autosa_sdp_rdma_split: splits one wide read-DMA return word into a
// sequence of narrow beats, lowest segment first.
//   16-bit mode (cfg_dp_8=0): RATIO beats, each a full NW-bit segment.
//   8-bit mode  (cfg_dp_8=1): 2*RATIO beats, each an NHW-bit half-segment
//                             zero-extended into the low half of the beat.
// Ports:
//   autosa_core_clk / autosa_core_rst : clock, synchronous active-high reset
//   cfg_dp_8                          : mode, latched on word acceptance
//   inp_pvld / inp_prdy / inp_data    : wide word handshake (WW bits)
//   out_pvld / out_prdy / out_data    : narrow beat handshake (NW bits)
//   out_last                          : final beat of the current word
module sa_autosa_sdp_rdma_split #(
  parameter int unsigned WW    = 256,
  parameter int unsigned NW    = 64,
  parameter int unsigned NHW   = NW / 2,
  parameter int unsigned RATIO = WW / NW
) (
  input  logic          autosa_core_clk,
  input  logic          autosa_core_rst,
  input  logic          cfg_dp_8,
  input  logic          inp_pvld,
  output logic          inp_prdy,
  input  logic [WW-1:0] inp_data,
  output logic          out_pvld,
  input  logic          out_prdy,
  output logic [NW-1:0] out_data,
  output logic          out_last
);

  // 4 bits covers the largest beat index, 2*8-1 = 15.
  localparam int unsigned CW = 4;
  // Wide enough to hold any legal bit offset into the holding register.
  localparam int unsigned OW = $clog2(WW) + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e          state_q;
  logic [WW-1:0]   hold_data_q;
  logic [CW-1:0]   cnt_q;
  logic            mode_q;

  logic            hold_vld;
  logic            is_last;
  logic            out_hs;
  logic            inp_hs;
  logic [OW-1:0]   full_off;
  logic [OW-1:0]   half_off;

  assign hold_vld = (state_q == ST_FULL);
  assign is_last  = mode_q ? (cnt_q == CW'(2 * RATIO - 1))
                           : (cnt_q == CW'(RATIO - 1));

  // Ready looks through to out_prdy on the last beat so consecutive words
  // stream without an idle cycle between them.
  assign inp_prdy = !hold_vld || (out_prdy && is_last);
  assign out_pvld = hold_vld;
  assign out_last = hold_vld && is_last;

  assign out_hs   = hold_vld && out_prdy;
  assign inp_hs   = inp_pvld && inp_prdy;

  // Beat counter, latched mode and FSM state.
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (inp_hs) begin
            state_q <= ST_FULL;
            cnt_q   <= '0;
            mode_q  <= cfg_dp_8;
          end
        end
        ST_FULL: begin
          if (inp_hs) begin
            // Only reachable on the last-beat handshake: reload in place.
            cnt_q  <= '0;
            mode_q <= cfg_dp_8;
          end else if (out_hs) begin
            if (is_last) begin
              state_q <= ST_EMPTY;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Data holding register; contents are meaningless while empty.
  always_ff @(posedge autosa_core_clk) begin
    if (inp_hs) begin
      hold_data_q <= inp_data;
    end
  end

  assign full_off = OW'(cnt_q) * OW'(NW);
  assign half_off = OW'(cnt_q) * OW'(NHW);

  // Beat select; the unused offset may overrun in the other mode but is
  // never routed to the output.
  always_comb begin
    out_data = '0;
    if (mode_q) begin
      out_data = {{(NW - NHW){1'b0}}, hold_data_q[half_off +: NHW]};
    end else begin
      out_data = hold_data_q[full_off +: NW];
    end
  end

endmodule

// File: tb/tb_sa_autosa_sdp_rdma_split.sv
// Scoreboard bench for sa_autosa_sdp_rdma_split: expected beats are queued
// when a word is accepted and compared as narrow beats are handed off.
module tb_sa_autosa_sdp_rdma_split;

  localparam int unsigned WW    = 256;
  localparam int unsigned NW    = 64;
  localparam int unsigned NHW   = 32;
  localparam int unsigned RATIO = 4;

  typedef struct packed {
    logic [NW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_dp_8;
  logic          inp_pvld;
  logic          inp_prdy;
  logic [WW-1:0] inp_data;
  logic          out_pvld;
  logic          out_prdy;
  logic [NW-1:0] out_data;
  logic          out_last;

  beat_t sb[$];
  int    n_checks   = 0;
  int    n_pass     = 0;
  int    beats_seen = 0;
  bit    mon_en     = 1'b0;
  int    bp_mode    = 0;

  always #5 clk = ~clk;

  sa_autosa_sdp_rdma_split #(
    .WW(WW), .NW(NW), .NHW(NHW), .RATIO(RATIO)
  ) u_dut (
    .autosa_core_clk (clk),
    .autosa_core_rst (rst),
    .cfg_dp_8        (cfg_dp_8),
    .inp_pvld        (inp_pvld),
    .inp_prdy        (inp_prdy),
    .inp_data        (inp_data),
    .out_pvld        (out_pvld),
    .out_prdy        (out_prdy),
    .out_data        (out_data),
    .out_last        (out_last)
  );

  task automatic check_eq(input string tag, input logic [NW-1:0] got,
                          input logic [NW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push_word(input logic [WW-1:0] d, input logic m);
    int    n;
    beat_t b;
    n = m ? 2 * RATIO : RATIO;
    for (int k = 0; k < n; k++) begin
      if (m) b.data = {{(NW - NHW){1'b0}}, d[k * NHW +: NHW]};
      else   b.data = d[k * NW +: NW];
      b.last = (k == n - 1);
      sb.push_back(b);
    end
  endtask

  // Monitor: compare against the model, then advance the model with the
  // handshakes that will occur at the coming rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic m_rdy;
      if (sb.size() > 0) begin
        check_eq("out_pvld", 64'(out_pvld), 64'd1);
        check_eq("out_data", out_data, sb[0].data);
        check_eq("out_last", 64'(out_last), 64'(sb[0].last));
        m_rdy = out_prdy && sb[0].last;
      end else begin
        check_eq("idle_out_pvld", 64'(out_pvld), 64'd0);
        check_eq("idle_out_last", 64'(out_last), 64'd0);
        m_rdy = 1'b1;
      end
      check_eq("inp_prdy", 64'(inp_prdy), 64'(m_rdy));
      if (rst) begin
        sb.delete();
      end else begin
        if (sb.size() > 0 && out_prdy) begin
          void'(sb.pop_front());
          beats_seen++;
        end
        if (inp_pvld && m_rdy) push_word(inp_data, cfg_dp_8);
      end
    end
  end

  // Output ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    int ph = 0;
    out_prdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1:       out_prdy = (ph % 3 == 0);
        2:       out_prdy = ($urandom_range(0, 2) != 0);
        default: out_prdy = 1'b1;
      endcase
      ph++;
    end
  end

  task automatic send_word(input logic [WW-1:0] d, input logic m);
    int   cyc = 0;
    logic acc = 1'b0;
    inp_data = d;
    cfg_dp_8 = m;
    inp_pvld = 1'b1;
    while (!acc && cyc < 500) begin
      @(negedge clk);
      acc = inp_prdy && !rst;
      @(posedge clk);
      #1;
      cyc++;
    end
    inp_pvld = 1'b0;
    if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_beats(input int n);
    int start = beats_seen;
    int cyc   = 0;
    while (beats_seen < start + n && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (beats_seen < start + n) check_eq("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (sb.size() > 0 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (sb.size() > 0) check_eq("drain_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] digit_word();
    logic [WW-1:0] d;
    for (int s = 0; s < RATIO; s++) d[s * NW +: NW] = {16{4'(s + 1)}};
    return d;
  endfunction

  function automatic logic [WW-1:0] half_word(input int base);
    logic [WW-1:0] d;
    for (int k = 0; k < 2 * RATIO; k++) d[k * NHW +: NHW] = NHW'(base + k);
    return d;
  endfunction

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] d;
    for (int k = 0; k < WW / 32; k++) d[k * 32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    rst      = 1'b1;
    inp_pvld = 1'b0;
    inp_data = '0;
    cfg_dp_8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_pvld", 64'(out_pvld), 64'd0);
    check_eq("rst_out_last", 64'(out_last), 64'd0);
    check_eq("rst_inp_prdy", 64'(inp_prdy), 64'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // 16-bit single word, digit-filled segments
    send_word(digit_word(), 1'b0);
    wait_drain();

    // 8-bit mode, incrementing halves
    send_word(half_word(0), 1'b1);
    wait_drain();

    // Back-to-back words with inp_pvld held high
    send_word(digit_word(), 1'b0);
    send_word(~digit_word(), 1'b0);
    send_word(half_word(16), 1'b0);
    wait_drain();

    // Backpressure mid-word
    bp_mode = 1;
    send_word(half_word(32), 1'b0);
    send_word(half_word(48), 1'b1);
    wait_drain();
    bp_mode = 0;
    wait_drain();

    // Mode change while a word is in flight
    send_word(digit_word(), 1'b0);
    wait_beats(2);
    cfg_dp_8 = 1'b1;
    send_word(half_word(64), 1'b1);
    wait_drain();

    // Reset mid-word discards the rest of the word
    send_word(~digit_word(), 1'b0);
    wait_beats(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_pvld", 64'(out_pvld), 64'd0);
    check_eq("midrst_inp_prdy", 64'(inp_prdy), 64'd1);
    @(posedge clk);
    #1;
    send_word(digit_word(), 1'b0);
    wait_drain();

    // Random data, modes and backpressure
    bp_mode = 2;
    for (int i = 0; i < 8; i++) send_word(rand_word(), 1'($urandom_range(0, 1)));
    wait_drain();
    bp_mode = 0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sa_autosa_sdp_rdma_split.md
Name: sa_autosa_sdp_rdma_split

Overview:
- Width-splitting stage on the SDP read-DMA return path; the mirror of the write-side narrow-to-wide packer.
- Accepts one wide word of WW bits per input handshake.
- Emits it as a sequence of narrow NW-bit beats, lowest segment first.
- In 16-bit mode each beat carries a full NW-bit segment; in 8-bit mode (cfg_dp_8=1) each beat carries an NHW-bit half-segment in its low half.

Parameters:
- WW, 256, wide input word width in bits.
- NW, 64, narrow output beat width in bits.
- NHW, NW/2, half-beat width used in 8-bit mode.
- RATIO, WW/NW, beats per word in 16-bit mode; legal values 1, 2, 4, 8.

Ports:
- autosa_core_clk  input  1  core clock; all state updates on its rising edge.
- autosa_core_rst  input  1  synchronous, active-high reset.
- cfg_dp_8  input  1  1 = 8-bit mode (2*RATIO half beats per word), 0 = 16-bit mode (RATIO full beats per word).
- inp_pvld  input  1  wide word valid.
- inp_prdy  output  1  wide word ready.
- inp_data  input  WW  wide word.
- out_pvld  output  1  narrow beat valid.
- out_prdy  input  1  narrow beat ready.
- out_data  output  NW  narrow beat.
- out_last  output  1  marks the final beat of the current wide word.

Behaviour:
- Clock and reset: one clock, autosa_core_clk. Reset is synchronous and active-high on autosa_core_rst.
- Reset state: hold_vld=0, cnt=0, mode_q=0. Resulting outputs: out_pvld=0, out_last=0, inp_prdy=1. The data register is not reset. out_data is don't-care while out_pvld=0.
- State: holding register hold_data[WW-1:0], hold_vld, 4-bit beat counter cnt, latched mode mode_q.
- Two-state FSM on hold_vld:
  - EMPTY: inp_pvld=1 -> capture inp_data and cfg_dp_8, cnt<=0, go to FULL.
  - FULL: each out_pvld&out_prdy advances cnt. On the last-beat handshake, cnt<=0 and the FSM returns to EMPTY, unless a new word is accepted in the same cycle, in which case it stays FULL with the new data.
- Last beat: is_last = mode_q ? (cnt==2*RATIO-1) : (cnt==RATIO-1). out_last = hold_vld & is_last.
- Input ready: inp_prdy = !hold_vld | (out_prdy & is_last). Combinational from out_prdy; this gives zero-bubble back-to-back words.
- Latency: first beat appears on out_data the cycle after input acceptance.
- Throughput: one narrow beat per cycle while out_prdy=1.
- Beat data:
  - 16-bit mode: out_data = hold_data[cnt*NW +: NW].
  - 8-bit mode: out_data = {NHW zeros, hold_data[cnt*NHW +: NHW]}.
- Mode latching: cfg_dp_8 is sampled only on word acceptance. A change while FULL does not affect the word in flight.
- Backpressure: out_prdy=0 holds cnt, out_data and out_last stable. out_pvld never drops without a handshake.
- Simultaneous last-beat handshake and input acceptance: the new word loads, cnt=0, and the first beat of the new word is presented the next cycle.
- RATIO=1 in 16-bit mode: every beat is last, so inp_prdy follows out_prdy while FULL.
- Reset mid-word: the partially sent word is discarded. No further beats are emitted and the word is not resumed.
- inp_data is not examined when inp_pvld=0.
- Counter: 4 bits is sufficient because the maximum is 2*8-1=15.

Test Plan:
- 16-bit single word (WW=256, NW=64, RATIO=4, cfg_dp_8=0): inp_data=0x4444..3333..2222..1111 (each 64-bit segment filled with its digit), out_prdy=1 -> 4 beats 0x1111..,0x2222..,0x3333..,0x4444.. on consecutive cycles starting 1 cycle after acceptance; out_last only on the 4th beat; inp_prdy=0 during beats 1-3.
- 8-bit mode, cfg_dp_8=1, inp_data with byte-wise incrementing 32-bit halves 0x00000000..0x00000007 -> 8 beats; out_data[63:32]=0 on every beat; beat k low half = k; out_last on beat 8.
- Back-to-back: inp_pvld held high with 3 words, out_prdy=1 -> 12 contiguous beats with no idle cycle; each word accepted in the cycle of the previous word's last beat.
- Backpressure: out_prdy toggled 1,0,0,1,... mid-word -> out_data/out_last stable during stalls; no beat lost or duplicated; beat order unchanged.
- Mode change mid-word: word accepted with cfg_dp_8=0, cfg_dp_8 switched to 1 after beat 2 -> still exactly 4 full beats; the next word accepted uses 8 half beats.
- Reset mid-word: assert autosa_core_rst after beat 2 for one cycle -> out_pvld=0 and inp_prdy=1 next cycle; a new word then produces beats starting from segment 0.
